// File: rtl/muldiv_pkg.sv
// Shared types for the execute-stage multiply/divide sequencer.
//   muldiv_op_t : operation encoding carried on req_op
//   md_state_t  : sequencer state
//   md_hilo_t   : {hi, lo} result word
// Helper functions decode operation classes and form 32-bit magnitudes.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    localparam int MD_DIV_ITERS = 32;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_hilo_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself and is
    // then treated as an unsigned magnitude downstream.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               load dividend/divisor and begin MD_DIV_ITERS steps
//   abort               cancel any running division (wins over start)
//   dividend, divisor   unsigned 32-bit operands sampled on start
//   done                high during the cycle that performs the final step
//   q, r                quotient/remainder produced by this cycle's step;
//                       meaningful only while done is high
// A zero divisor never borrows, so the quotient fills with ones and the
// dividend shifts through unchanged into the remainder.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    localparam int CNT_W = 6;

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      rem_q, rem_d;   // {partial remainder, dividend/quotient}
    logic [31:0]      dsr_q, dsr_d;

    logic [32:0]      trial;
    logic [63:0]      step;

    // The shifted partial remainder can briefly need 33 bits, so the trial
    // subtraction looks at rem_q[63:31] before the shift is committed.
    always_comb begin
        trial = rem_q[63:31] - {1'b0, dsr_q};
        if (trial[32]) begin
            step = {rem_q[62:0], 1'b0};
        end else begin
            step = {trial[31:0], rem_q[30:0], 1'b1};
        end
    end

    // Outputs come straight from the final step so the controller can
    // register the corrected result on the same edge the divider finishes.
    assign done = run_q && (cnt_q == CNT_W'(1));
    assign q    = step[31:0];
    assign r    = step[63:32];

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        dsr_d = dsr_q;
        if (abort) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            run_d = 1'b1;
            cnt_d = CNT_W'(MD_DIV_ITERS);
            rem_d = {32'd0, dividend};
            dsr_d = divisor;
        end else if (run_q) begin
            rem_d = step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide unit.
// Parameters:
//   MUL_STAGES   product pipeline depth, 1..8
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   req_valid    per-lane request (lane 1 is older and wins)
//   req_op       per-lane muldiv_op_t
//   req_a/b      per-lane bypassed operands
//   stall_in     downstream stall; holds a finished result
//   flush        cancels any in-flight or held operation
//   busy         combinational execute-stage wait request
//   res_valid    res_hilo valid; res_lane names the owning lane
//   res_hilo     {HI, LO}
// Operands are reduced to magnitudes at acceptance; signs are re-applied
// when the result is registered on entry to DONE.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_STAGES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [1:0][1:0]  req_op,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    input  logic             stall_in,
    input  logic             flush,
    output logic             busy,
    output logic             res_valid,
    output logic             res_lane,
    output logic [63:0]      res_hilo
);

    localparam int CNT_W = 3;   // holds MUL_STAGES-1 for depths up to 8

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lane_q, lane_d;
    logic             na_q, na_d;
    logic             nb_q, nb_d;
    logic             res_valid_q, res_valid_d;
    logic             res_lane_q, res_lane_d;
    md_hilo_t         res_hilo_q, res_hilo_d;

    // ---------------------------------------------------------------
    // Request selection: lane 1 wins whenever it is requesting.
    // ---------------------------------------------------------------
    logic        sel_lane;
    muldiv_op_t  sel_op;
    logic [31:0] sel_a, sel_b;
    logic        sel_na, sel_nb;
    logic [31:0] mag_a, mag_b;
    logic        accept;
    logic        div_start;

    assign sel_lane  = req_valid[1];
    assign sel_op    = muldiv_op_t'(req_op[sel_lane]);
    assign sel_a     = req_a[sel_lane];
    assign sel_b     = req_b[sel_lane];
    assign sel_na    = op_is_signed(sel_op) & sel_a[31];
    assign sel_nb    = op_is_signed(sel_op) & sel_b[31];
    assign mag_a     = abs32(sel_a, sel_na);
    assign mag_b     = abs32(sel_b, sel_nb);

    assign accept    = (state_q == ST_IDLE) && (|req_valid) && !flush;
    assign div_start = accept && op_is_div(sel_op);

    assign busy      = accept || (state_q == ST_MUL) || (state_q == ST_DIV);

    // ---------------------------------------------------------------
    // Multiplier pipe. Stage 0 captures the product at acceptance, so
    // the last stage holds it during the final MUL cycle; the stage
    // registers are there for synthesis to retime the multiplier into.
    // ---------------------------------------------------------------
    logic [63:0] mul_prod;
    logic        mul_vld;

    generate
        for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_pipe
            logic [63:0] prod_d, prod_q;
            logic        vld_d, vld_q;

            if (gi == 0) begin : g_head
                assign prod_d = 64'(mag_a) * 64'(mag_b);
                assign vld_d  = accept && !op_is_div(sel_op);
            end else begin : g_tail
                assign prod_d = g_pipe[gi-1].prod_q;
                assign vld_d  = g_pipe[gi-1].vld_q && !flush;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prod_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    prod_q <= prod_d;
                    vld_q  <= vld_d;
                end
            end
        end
    endgenerate

    assign mul_prod = g_pipe[MUL_STAGES-1].prod_q;
    assign mul_vld  = g_pipe[MUL_STAGES-1].vld_q;

    // ---------------------------------------------------------------
    // Divider
    // ---------------------------------------------------------------
    logic        div_done;
    logic [31:0] div_q, div_r;

    div_iter u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (flush),
        .dividend (mag_a),
        .divisor  (mag_b),
        .done     (div_done),
        .q        (div_q),
        .r        (div_r)
    );

    // ---------------------------------------------------------------
    // Sign correction. Remainder follows the dividend's sign.
    // ---------------------------------------------------------------
    md_hilo_t mul_res, div_res;

    assign mul_res    = (na_q ^ nb_q) ? -mul_prod : mul_prod;
    assign div_res.lo = (na_q ^ nb_q) ? -div_q : div_q;
    assign div_res.hi = na_q ? -div_r : div_r;

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        na_d        = na_q;
        nb_d        = nb_q;
        res_valid_d = res_valid_q;
        res_lane_d  = res_lane_q;
        res_hilo_d  = res_hilo_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    lane_d = sel_lane;
                    na_d   = sel_na;
                    nb_d   = sel_nb;
                    if (op_is_div(sel_op)) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_STAGES - 1);
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (mul_vld) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_lane_d  = lane_q;
                    res_hilo_d  = mul_res;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_lane_d  = lane_q;
                    res_hilo_d  = div_res;
                end
            end
            ST_DONE: begin
                if (!stall_in) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides everything, including a result being held.
        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            res_valid_d = 1'b0;
            res_lane_d  = 1'b0;
            res_hilo_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lane_q      <= 1'b0;
            na_q        <= 1'b0;
            nb_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_lane_q  <= 1'b0;
            res_hilo_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            na_q        <= na_d;
            nb_q        <= nb_d;
            res_valid_q <= res_valid_d;
            res_lane_q  <= res_lane_d;
            res_hilo_q  <= res_hilo_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_lane  = res_lane_q;
    assign res_hilo  = res_hilo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed test-plan vectors plus
// randomized operations scored against a plain-arithmetic reference.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MS      = 3;
    localparam int MUL_LAT = MS + 1;
    localparam int DIV_LAT = MD_DIV_ITERS + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0][1:0]  req_op = '0;
    logic [1:0][31:0] req_a = '0;
    logic [1:0][31:0] req_b = '0;
    logic             stall_in = 1'b0;
    logic             flush = 1'b0;
    logic             busy;
    logic             res_valid;
    logic             res_lane;
    logic [63:0]      res_hilo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_STAGES(MS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .stall_in  (stall_in),
        .flush     (flush),
        .busy      (busy),
        .res_valid (res_valid),
        .res_lane  (res_lane),
        .res_hilo  (res_hilo)
    );

    // Reference: what the instruction means arithmetically.
    function automatic logic [63:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT:  return 64'(sa * sb);
            MD_MULTU: return 64'(a) * 64'(b);
            MD_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) begin
                    // all-ones quotient magnitude, remainder = dividend
                    q = (sa < 0) ? 32'd1 : 32'hFFFFFFFF;
                    r = a;
                end else begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end
                return {r, q};
            end
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] corners [6];
        corners = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd2};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 1000));
        return $urandom;
    endfunction

    task automatic drive_req(input logic [1:0] vld,
                             input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                             input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0);
        req_valid = vld;
        req_op[1] = op1; req_a[1] = a1; req_b[1] = b1;
        req_op[0] = op0; req_a[0] = a0; req_b[0] = b0;
    endtask

    // Called just after the edge that opens the accept cycle.
    task automatic run_txn(input logic exp_lane, input logic [63:0] exp_hilo,
                           input int exp_lat, input string name);
        int c;
        bit busy_ok;
        c = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        if (busy !== 1'b1 || res_valid !== 1'b0) busy_ok = 1'b0;
        while (res_valid !== 1'b1 && c < 80) begin
            @(negedge clk);
            c++;
            if (res_valid !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++;
        if (c != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, c, exp_lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy: got low before result, expected high cycles 0..%0d", name, exp_lat - 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
        end
        checks++;
        if (res_lane !== exp_lane) begin
            errors++;
            $display("FAIL %s res_lane: got %b expected %b", name, res_lane, exp_lane);
        end
        checks++;
        if (res_hilo !== exp_hilo) begin
            errors++;
            $display("FAIL %s res_hilo: got %h expected %h", name, res_hilo, exp_hilo);
        end
        $display("TXN %-18s lane=%0d hilo=%h cycles=%0d", name, res_lane, res_hilo, c);
    endtask

    task automatic end_txn(input string name);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got res_valid=%b busy=%b expected 0 0", name, res_valid, busy);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #12;
        checks++;
        if (res_valid !== 1'b0 || res_lane !== 1'b0 || res_hilo !== 64'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: got valid=%b lane=%b hilo=%h busy=%b expected all 0",
                     res_valid, res_lane, res_hilo, busy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul();
        @(posedge clk); #1;
        drive_req(2'b10, MD_MULT, 32'hFFFFFFFD, 32'd5, MD_MULTU, 32'd1, 32'd1);
        run_txn(1'b1, 64'hFFFFFFFF_FFFFFFF1, MUL_LAT, "mult_neg");
        end_txn("mult_neg");
        @(posedge clk); #1;
        drive_req(2'b01, MD_DIV, 32'd9, 32'd9, MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_txn(1'b0, 64'hFFFFFFFE_00000001, MUL_LAT, "multu_max");
        end_txn("multu_max");
    endtask

    task automatic test_div();
        @(posedge clk); #1;
        drive_req(2'b10, MD_DIV, 32'hFFFFFFF9, 32'd2, MD_MULT, 32'd3, 32'd3);
        run_txn(1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, DIV_LAT, "div_neg");
        end_txn("div_neg");
        @(posedge clk); #1;
        drive_req(2'b01, MD_MULT, 32'd0, 32'd0, MD_DIVU, 32'd7, 32'd0);
        run_txn(1'b0, {32'd7, 32'hFFFFFFFF}, DIV_LAT, "divu_by_zero");
        end_txn("divu_by_zero");
    endtask

    task automatic test_priority();
        @(posedge clk); #1;
        drive_req(2'b11, MD_DIVU, 32'd100, 32'd7, MD_MULT, 32'd3, 32'd4);
        run_txn(1'b1, {32'd2, 32'd14}, DIV_LAT, "both_lanes");
        end_txn("both_lanes");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        drive_req(2'b01, MD_MULT, 32'd0, 32'd0, MD_MULT, 32'd9, 32'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_lane !== 1'b0 || res_hilo !== 64'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b lane=%b hilo=%h busy=%b expected all 0",
                     res_valid, res_lane, res_hilo, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        drive_req(2'b01, MD_MULT, 32'd0, 32'd0, MD_MULT, 32'd9, 32'hFFFFFFFF);
        run_txn(1'b0, 64'hFFFFFFFF_FFFFFFF7, MUL_LAT, "mult_after_reset");
        end_txn("mult_after_reset");
    endtask

    task automatic test_stall();
        int c;
        bit stable;
        logic [63:0] held;
        @(posedge clk); #1;
        stall_in = 1'b1;
        drive_req(2'b10, MD_DIV, 32'hFFFFFF9C, 32'd9, MD_MULT, 32'd1, 32'd1);
        c = 0;
        @(negedge clk);
        while (res_valid !== 1'b1 && c < 80) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c != DIV_LAT) begin
            errors++;
            $display("FAIL stall latency: got %0d cycles, expected %0d", c, DIV_LAT);
        end
        held = res_hilo;
        checks++;
        if (held !== {32'hFFFFFFFF, 32'hFFFFFFF5}) begin
            errors++;
            $display("FAIL stall res_hilo: got %h expected %h", held, {32'hFFFFFFFF, 32'hFFFFFFF5});
        end
        stable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) stall_in = 1'b0;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_hilo !== held || busy !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL stall hold: got valid=%b hilo=%h busy=%b expected 1 %h 0",
                     res_valid, res_hilo, busy, held);
        end
        $display("TXN %-18s lane=%0d hilo=%h cycles=%0d", "div_stalled", res_lane, res_hilo, c);
        end_txn("div_stalled");
    endtask

    task automatic test_flush();
        bit quiet;
        // flush together with a request: nothing accepted
        @(posedge clk); #1;
        drive_req(2'b01, MD_MULT, 32'd0, 32'd0, MD_MULT, 32'd5, 32'd5);
        flush = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_req busy: got %b expected 0", busy);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = '0;
        quiet = 1'b1;
        repeat (MUL_LAT + 3) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL flush_req accepted: got res_valid/busy activity, expected none");
        end
        // flush in DIV cycle 10
        @(posedge clk); #1;
        drive_req(2'b01, MD_MULT, 32'd0, 32'd0, MD_DIV, 32'd1000, 32'd3);
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_div next: got busy=%b res_valid=%b expected 0 0", busy, res_valid);
        end
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL flush_div quiet: got a result after flush, expected none");
        end
        @(posedge clk); #1;
        drive_req(2'b10, MD_MULT, 32'd6, 32'd7, MD_DIV, 32'd1, 32'd1);
        run_txn(1'b1, 64'd42, MUL_LAT, "mult_after_flush");
        end_txn("mult_after_flush");
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        drive_req(2'b01, MD_MULT, 32'd0, 32'd0, MD_MULTU, 32'd123456, 32'd1000);
        run_txn(1'b0, 64'd123456000, MUL_LAT, "b2b_first");
        @(posedge clk); #1;
        drive_req(2'b10, MD_DIV, 32'd50, 32'hFFFFFFF9, MD_MULT, 32'd0, 32'd0);
        run_txn(1'b1, {32'd1, 32'hFFFFFFF9}, DIV_LAT, "b2b_second");
        @(posedge clk); #1;
        drive_req(2'b01, MD_MULT, 32'd0, 32'd0, MD_MULT, 32'h80000000, 32'hFFFFFFFF);
        run_txn(1'b0, 64'h00000000_80000000, MUL_LAT, "b2b_third");
        end_txn("b2b_third");
    endtask

    task automatic test_random();
        logic [1:0]  vld, op0, op1, wop;
        logic [31:0] a0, b0, a1, b1, wa, wb;
        logic        wl;
        for (int i = 0; i < 16; i++) begin
            op0 = 2'($urandom_range(0, 3));
            op1 = 2'($urandom_range(0, 3));
            a0 = rnd_operand(); b0 = rnd_operand();
            a1 = rnd_operand(); b1 = rnd_operand();
            vld = 2'($urandom_range(1, 3));
            wl  = vld[1];
            wop = wl ? op1 : op0;
            wa  = wl ? a1 : a0;
            wb  = wl ? b1 : b0;
            @(posedge clk); #1;
            drive_req(vld, op1, a1, b1, op0, a0, b0);
            run_txn(wl, ref_result(wop, wa, wb),
                    (wop == MD_DIV || wop == MD_DIVU) ? DIV_LAT : MUL_LAT,
                    $sformatf("rand%0d_op%0d", i, wop));
            end_txn("rand");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_priority();
        test_reset_mid();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
